// File: rtl/timer_multi_ch_if.sv
// Configuration and readback bus between the core's memory-mapped
// config logic (master) and timer_multi_ch (slave).
// cfgWe writes cfgLoad/cfgMode into channel cfgCh; rdVal returns the
// live counter of channel rdCh combinationally.
interface timer_multi_ch_if #(
    parameter int N  = 32,
    parameter int CH = 4
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic          cfgWe;
    logic [CW-1:0] cfgCh;
    logic [N-1:0]  cfgLoad;
    logic          cfgMode;
    logic [CW-1:0] rdCh;
    logic [N-1:0]  rdVal;

    modport master (
        output cfgWe, cfgCh, cfgLoad, cfgMode, rdCh,
        input  rdVal
    );

    modport slave (
        input  cfgWe, cfgCh, cfgLoad, cfgMode, rdCh,
        output rdVal
    );
endinterface

// File: rtl/timer_multi_ch.sv
// timer_multi_ch: CH-channel N-bit up-counting timer.
// - Shared free-running prescaler: one tick every presc_i+1 clocks.
// - Per channel: periodic or one-shot mode, registered one-cycle terminal
//   pulse (endPulse_o) and a sticky interrupt flag (irq_o).
// - Load convention: to count X ticks, program load = X-1.
// - pwrOff_i freezes all state and forces endPulse_o/irq_o low.
// - Optional feature macro TIMER_CHAIN_EN: adds chain_i; when chain_i[i]
//   is set (i>0), channel i ticks on the terminal event of channel i-1
//   instead of the prescaler, cascading the two into one long period.
module timer_multi_ch #(
    parameter int N       = 32,
    parameter int CH      = 4,
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pwrOff_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [CH-1:0]      en_i,
    input  logic [CH-1:0]      irqClr_i,
`ifdef TIMER_CHAIN_EN
    input  logic [CH-1:0]      chain_i,
`endif
    output logic [CH-1:0]      endPulse_o,
    output logic [CH-1:0]      irq_o,
    timer_multi_ch_if.slave    cfgBus
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } chState_e;

    logic [PRESC_W-1:0] prescCnt_q;
    logic [PRESC_W-1:0] prescCnt_d;
    logic               prescTick;

    chState_e           state_q [CH];
    chState_e           state_d [CH];
    logic [N-1:0]       cnt_q   [CH];
    logic [N-1:0]       cnt_d   [CH];
    logic [N-1:0]       load_q  [CH];
    logic [N-1:0]       load_d  [CH];
    logic [CH-1:0]      mode_q;
    logic [CH-1:0]      mode_d;
    logic [CH-1:0]      end_q;
    logic [CH-1:0]      end_d;
    logic [CH-1:0]      irq_q;
    logic [CH-1:0]      irq_d;

    logic [CH-1:0]      cfgHit;
    logic [CH-1:0]      chTick;
    logic [CH-1:0]      active;
    logic [CH-1:0]      terminal;

    // Prescaler: wraps on reaching presc_i; '>=' also recovers at once if
    // presc_i is lowered below the running count instead of wrapping at 2^W.
    always_comb begin
        prescTick  = 1'b0;
        prescCnt_d = prescCnt_q;
        if (!pwrOff_i) begin
            if (prescCnt_q >= presc_i) begin
                prescTick  = 1'b1;
                prescCnt_d = '0;
            end else begin
                prescCnt_d = prescCnt_q + PRESC_W'(1);
            end
        end
    end

    // Per-channel tick source, activity and terminal event; a config write
    // to a channel suppresses its terminal event in the same cycle.
    always_comb begin
`ifdef TIMER_CHAIN_EN
        logic prevTerm;
        prevTerm = 1'b0;
`endif
        cfgHit   = '0;
        chTick   = '0;
        active   = '0;
        terminal = '0;
        for (int i = 0; i < CH; i++) begin
            cfgHit[i] = cfgBus.cfgWe && (cfgBus.cfgCh == CW'(i));
            chTick[i] = prescTick;
`ifdef TIMER_CHAIN_EN
            if ((i > 0) && chain_i[i]) begin
                chTick[i] = prevTerm;
            end
`endif
            active[i]   = !pwrOff_i && en_i[i] &&
                          ((state_q[i] == ST_RUN) || (state_q[i] == ST_PAUSE));
            terminal[i] = active[i] && chTick[i] && !cfgHit[i] &&
                          (cnt_q[i] >= load_q[i]);
`ifdef TIMER_CHAIN_EN
            prevTerm    = terminal[i];
`endif
        end
    end

    // Next-state logic per channel. A PAUSE channel with en set counts in
    // the same cycle it returns to RUN, so a pause costs exactly the number
    // of clocks en was low.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            load_d[i]  = load_q[i];
            mode_d[i]  = mode_q[i];
            end_d[i]   = 1'b0;
            irq_d[i]   = irq_q[i];

            if (!pwrOff_i) begin
                if (cfgHit[i]) begin
                    load_d[i]  = cfgBus.cfgLoad;
                    mode_d[i]  = cfgBus.cfgMode;
                    cnt_d[i]   = '0;
                    state_d[i] = ST_IDLE;
                end else begin
                    unique case (state_q[i])
                        ST_IDLE: begin
                            cnt_d[i] = '0;
                            if (en_i[i]) begin
                                state_d[i] = ST_RUN;
                            end
                        end
                        ST_RUN, ST_PAUSE: begin
                            state_d[i] = en_i[i] ? ST_RUN : ST_PAUSE;
                            if (active[i] && chTick[i]) begin
                                if (terminal[i]) begin
                                    cnt_d[i] = '0;
                                    if (mode_q[i]) begin
                                        state_d[i] = ST_DONE;
                                    end
                                end else begin
                                    cnt_d[i] = cnt_q[i] + N'(1);
                                end
                            end
                        end
                        ST_DONE: begin
                            cnt_d[i] = '0;
                        end
                        default: begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end
                    endcase
                end

                end_d[i] = terminal[i];
                if (terminal[i]) begin
                    irq_d[i] = 1'b1;
                end else if (irqClr_i[i]) begin
                    irq_d[i] = 1'b0;
                end
            end
        end
    end

    // State register with synchronous reset; reset overrides pwrOff_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescCnt_q <= '0;
            mode_q     <= '0;
            end_q      <= '0;
            irq_q      <= '0;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                load_q[i]  <= '0;
            end
        end else begin
            prescCnt_q <= prescCnt_d;
            mode_q     <= mode_d;
            end_q      <= end_d;
            irq_q      <= irq_d;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                load_q[i]  <= load_d[i];
            end
        end
    end

    // Outputs: pulse/flag masked while powered off, live counter readback.
    always_comb begin
        endPulse_o   = pwrOff_i ? '0 : end_q;
        irq_o        = pwrOff_i ? '0 : irq_q;
        cfgBus.rdVal = '0;
        for (int i = 0; i < CH; i++) begin
            if (cfgBus.rdCh == CW'(i)) begin
                cfgBus.rdVal = cnt_q[i];
            end
        end
    end

endmodule

// File: tb/tb_timer_multi_ch.sv
// Self-checking bench for timer_multi_ch: a behavioural channel model
// predicts endPulse/irq/rdVal each cycle into a scoreboard queue, plus
// directed checks of the key timing scenarios.
module tb_timer_multi_ch;

    localparam int N  = 32;
    localparam int CH = 4;

    typedef struct {
        logic [CH-1:0] endP;
        logic [CH-1:0] irq;
        logic [N-1:0]  rd;
    } expect_t;

    logic          clk;
    logic          rst;
    logic          pwrOff;
    logic [7:0]    presc;
    logic [CH-1:0] en;
    logic [CH-1:0] irqClr;
`ifdef TIMER_CHAIN_EN
    logic [CH-1:0] chain;
`endif
    logic [CH-1:0] endPulse;
    logic [CH-1:0] irq;

    int            testsRun  = 0;
    int            failCount = 0;
    int            cyc       = 0;
    expect_t       expQ[$];

    int            mPc;
    int            mState [CH];
    logic [N-1:0]  mCnt   [CH];
    logic [N-1:0]  mLoad  [CH];
    bit            mMode  [CH];
    bit   [CH-1:0] mEnd;
    bit   [CH-1:0] mIrq;

    timer_multi_ch_if #(.N(N), .CH(CH)) cfgBus ();

    timer_multi_ch #(.N(N), .CH(CH), .PRESC_W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pwrOff_i   (pwrOff),
        .presc_i    (presc),
        .en_i       (en),
        .irqClr_i   (irqClr),
`ifdef TIMER_CHAIN_EN
        .chain_i    (chain),
`endif
        .endPulse_o (endPulse),
        .irq_o      (irq),
        .cfgBus     (cfgBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Behavioural model of one clock: 0=IDLE 1=RUN 2=PAUSE 3=DONE.
    task automatic modelStep();
        bit tk, myTick, carry, term, hit, act;
        if (rst) begin
            mPc  = 0;
            mEnd = '0;
            mIrq = '0;
            for (int c = 0; c < CH; c++) begin
                mState[c] = 0;
                mCnt[c]   = '0;
                mLoad[c]  = '0;
                mMode[c]  = 1'b0;
            end
        end else if (pwrOff) begin
            mEnd = '0;
        end else begin
            tk    = (mPc >= int'(presc));
            mPc   = tk ? 0 : mPc + 1;
            carry = 1'b0;
            for (int c = 0; c < CH; c++) begin
                myTick = tk;
`ifdef TIMER_CHAIN_EN
                if (c > 0 && chain[c]) myTick = carry;
`endif
                hit  = cfgBus.cfgWe && (int'(cfgBus.cfgCh) == c);
                act  = (mState[c] == 1 || mState[c] == 2) && en[c];
                term = !hit && act && myTick && (mCnt[c] >= mLoad[c]);
                mEnd[c] = term;
                if (hit) begin
                    mLoad[c]  = cfgBus.cfgLoad;
                    mMode[c]  = cfgBus.cfgMode;
                    mCnt[c]   = '0;
                    mState[c] = 0;
                end else if (mState[c] == 0) begin
                    if (en[c]) mState[c] = 1;
                end else if (mState[c] != 3) begin
                    if (act && myTick) begin
                        mState[c] = 1;
                        if (term) begin
                            mCnt[c] = '0;
                            if (mMode[c]) mState[c] = 3;
                        end else begin
                            mCnt[c] = mCnt[c] + 1;
                        end
                    end else begin
                        mState[c] = en[c] ? 1 : 2;
                    end
                end
                if (term) mIrq[c] = 1'b1;
                else if (irqClr[c]) mIrq[c] = 1'b0;
                carry = term;
            end
        end
    endtask

    // One clock: predict, push, clock the DUT, pop and compare.
    task automatic applyStimulus();
        expect_t e;
        modelStep();
        e.endP = pwrOff ? '0 : mEnd;
        e.irq  = pwrOff ? '0 : mIrq;
        e.rd   = mCnt[cfgBus.rdCh];
        expQ.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = expQ.pop_front();
        checkOutput("endPulse", 32'(endPulse), 32'(e.endP));
        checkOutput("irq", 32'(irq), 32'(e.irq));
        checkOutput("rdVal", cfgBus.rdVal, e.rd);
    endtask

    task automatic cfgWrite(input int ch, input logic [N-1:0] load, input bit mode);
        cfgBus.cfgWe   = 1'b1;
        cfgBus.cfgCh   = 2'(ch);
        cfgBus.cfgLoad = load;
        cfgBus.cfgMode = mode;
        applyStimulus();
        cfgBus.cfgWe   = 1'b0;
    endtask

    task automatic waitEnd(input int ch, input int bound, output int at);
        at = -1;
        for (int k = 0; k < bound; k++) begin
            applyStimulus();
            if (endPulse[ch]) begin
                at = cyc;
                break;
            end
        end
        checkOutput("waitEnd", 32'(at >= 0), 1);
    endtask

    task automatic waitCnt(input logic [N-1:0] val, input int bound);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            applyStimulus();
            if (cfgBus.rdVal == val) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("waitCnt", 32'(seen), 1);
    endtask

    initial begin
        int t0, t1, c0, pulses;
        rst = 1'b1; pwrOff = 1'b0; presc = 8'd0; en = '0; irqClr = '0;
        cfgBus.cfgWe = 1'b0; cfgBus.cfgCh = '0; cfgBus.cfgLoad = '0;
        cfgBus.cfgMode = 1'b0; cfgBus.rdCh = '0;
`ifdef TIMER_CHAIN_EN
        chain = '0;
`endif
        applyStimulus();
        applyStimulus();
        checkOutput("rstIrq", 32'(irq), 0);
        checkOutput("rstEnd", 32'(endPulse), 0);
        checkOutput("rstRd", cfgBus.rdVal, 0);
        rst = 1'b0;

        // Periodic ch0, load 4, prescaler off: pulse every 5 clocks.
        cfgWrite(0, 4, 1'b0);
        en[0] = 1'b1;
        waitEnd(0, 20, t0);
        checkOutput("t1IrqSet", 32'(irq[0]), 1);
        waitEnd(0, 20, t1);
        checkOutput("t1Period", 32'(t1 - t0), 5);
        irqClr[0] = 1'b1;
        applyStimulus();
        irqClr[0] = 1'b0;
        checkOutput("t1IrqClr", 32'(irq[0]), 0);

        // One-shot ch1, load 1, prescaler 3: single pulse 8 clocks after the write.
        c0 = cyc;
        presc = 8'd3;
        cfgWrite(1, 1, 1'b1);
        en[1] = 1'b1;
        cfgBus.rdCh = 2'd1;
        waitEnd(1, 20, t0);
        checkOutput("t2Latency", 32'(t0 - c0), 8);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            applyStimulus();
            if (endPulse[1]) pulses++;
        end
        checkOutput("t2NoRepeat", 32'(pulses), 0);
        checkOutput("t2RdDone", cfgBus.rdVal, 0);
        presc = 8'd0;

        // Pause ch2 at count 2 for 10 clocks, then resume.
        cfgWrite(2, 9, 1'b0);
        cfgBus.rdCh = 2'd2;
        en[2] = 1'b1;
        waitCnt(2, 20);
        en[2] = 1'b0;
        repeat (10) applyStimulus();
        checkOutput("t3Hold", cfgBus.rdVal, 2);
        en[2] = 1'b1;
        applyStimulus();
        checkOutput("t3Resume3", cfgBus.rdVal, 3);
        applyStimulus();
        checkOutput("t3Resume4", cfgBus.rdVal, 4);

        // Config write on ch0's terminal cycle suppresses End/Irq set.
        cfgBus.rdCh = 2'd0;
        waitEnd(0, 20, t0);
        checkOutput("t4IrqPre", 32'(irq[0]), 1);
        waitCnt(4, 20);
        cfgWrite(0, 4, 1'b0);
        checkOutput("t4NoEnd", 32'(endPulse[0]), 0);
        checkOutput("t4IrqKept", 32'(irq[0]), 1);

        // Irq set and clear in the same terminal cycle: set wins.
        cfgWrite(3, 4, 1'b0);
        en[3] = 1'b1;
        cfgBus.rdCh = 2'd3;
        waitCnt(4, 20);
        irqClr[3] = 1'b1;
        applyStimulus();
        irqClr[3] = 1'b0;
        checkOutput("t4IrqSetWins", 32'(irq[3]), 1);
        checkOutput("t4End3", 32'(endPulse[3]), 1);

        // Power-off freeze, resume, then reset while powered off.
        cfgBus.rdCh = 2'd2;
        waitCnt(5, 20);
        pwrOff = 1'b1;
        repeat (6) applyStimulus();
        checkOutput("t5Frozen", cfgBus.rdVal, 5);
        checkOutput("t5IrqMasked", 32'(irq), 0);
        checkOutput("t5EndMasked", 32'(endPulse), 0);
        pwrOff = 1'b0;
        applyStimulus();
        checkOutput("t5Resume", cfgBus.rdVal, 6);
        checkOutput("t5IrqBack", 32'(irq[3]), 1);
        pwrOff = 1'b1;
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        en = '0;
        rst = 1'b0;
        pwrOff = 1'b0;
        applyStimulus();
        checkOutput("t5RstIrq", 32'(irq), 0);
        checkOutput("t5RstRd", cfgBus.rdVal, 0);
        checkOutput("t5RstEnd", 32'(endPulse), 0);

`ifdef TIMER_CHAIN_EN
        // Cascade ch0 (load 3) into ch1 (load 2): ch1 period 12 clocks.
        presc = 8'd0;
        chain = 4'b0010;
        cfgWrite(0, 3, 1'b0);
        cfgWrite(1, 2, 1'b0);
        en = 4'b0011;
        waitEnd(1, 40, t0);
        checkOutput("t6Coincide", 32'(endPulse[0]), 1);
        waitEnd(1, 20, t1);
        checkOutput("t6Period", 32'(t1 - t0), 12);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
